// File: rtl/adc_downsample_packer.sv
// Decimates a two's-complement sample stream by DEC, buffers kept samples in a FIFO and
// serializes each one MSB-byte-first. Optional frame sync bytes: ADC_DOWNSAMPLE_PACKER_SYNC_EN.
module adc_downsample_packer #(
  parameter int OW         = 14,
  parameter int USBDW      = 8,
  parameter int DEC        = 20,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 1024
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [OW-1:0]    data_i,
  input  logic             valid_i,
  output logic [USBDW-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             overflow_o
);

  localparam int CW = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef ADC_DOWNSAMPLE_PACKER_SYNC_EN
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  typedef enum logic [2:0] {IDLE, HI, LO, SYNC0, SYNC1} state_e;
`else
  typedef enum logic [1:0] {IDLE, HI, LO} state_e;
`endif

  state_e state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [15:0]      mem_q [FIFO_DEPTH];
  logic             ovf_q, ovf_d;
  logic [USBDW-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [7:0]       lo_q, lo_d;

  logic             keep, push, pop, fetch, sync_start, empty, full;
  logic signed [OW-1:0] sdat;
  logic [15:0]      ext, head;

  // ---------------- decimator ----------------
  assign keep = valid_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (valid_i) cnt_d = (cnt_q == CW'(DEC - 1)) ? '0 : cnt_q + 1'b1;
  end

  // ---------------- sample FIFO ----------------
  assign sdat  = data_i;
  assign ext   = 16'(sdat);
  assign head  = mem_q[rd_q[AW-1:0]];
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // A pop on the same edge frees the slot; the head is read before the write lands.
  assign push  = keep && (!full || pop);

  always_comb begin
    wr_d  = wr_q + (AW+1)'(push);
    rd_d  = rd_q + (AW+1)'(pop);
    ovf_d = ovf_q | (keep & ~push);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q[AW-1:0]] <= ext;
  end

  // ---------------- packer ----------------
  assign fetch = ((state_q == IDLE) || ((state_q == LO) && ready_i)) && !empty;

`ifdef ADC_DOWNSAMPLE_PACKER_SYNC_EN
  logic [FW-1:0] fcnt_q, fcnt_d;
  // Frame boundary is judged on popped samples, so dropped ones never shift it.
  assign sync_start = fetch && (fcnt_q == '0);
  assign pop        = (fetch && !sync_start) || ((state_q == SYNC1) && ready_i);

  always_comb begin
    fcnt_d = fcnt_q;
    if (pop) fcnt_d = (fcnt_q == FW'(FRAME_LEN - 1)) ? '0 : fcnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) fcnt_q <= '0;
    else          fcnt_q <= fcnt_d;
  end
`else
  assign sync_start = 1'b0;
  assign pop        = fetch;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fetch) state_d = sync_start ? state_e'(3) : HI;
      HI:   if (ready_i) state_d = LO;
      LO:   if (ready_i) state_d = fetch ? (sync_start ? state_e'(3) : HI) : IDLE;
`ifdef ADC_DOWNSAMPLE_PACKER_SYNC_EN
      SYNC0: if (ready_i) state_d = SYNC1;
      SYNC1: if (ready_i) state_d = HI;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    lo_d    = lo_q;
    if (pop) begin
      data_d  = head[15:8];
      lo_d    = head[7:0];
      valid_d = 1'b1;
    end else if (sync_start) begin
      data_d  = 8'hA5;
      valid_d = 1'b1;
    end else begin
      case (state_q)
        HI:  if (ready_i) data_d = lo_q;
        LO:  if (ready_i) valid_d = 1'b0;
`ifdef ADC_DOWNSAMPLE_PACKER_SYNC_EN
        SYNC0: if (ready_i) data_d = 8'h5A;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      lo_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      lo_q    <= lo_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_adc_downsample_packer.sv
// Directed bench: two instances (DEC=20 and DEC=1) sharing clock and reset.
module tb_adc_downsample_packer;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [13:0] d20, d1;
  logic        v20, v1, r20, r1;
  logic [7:0]  o20, o1;
  logic        vo20, vo1, ov20, ov1;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] q20[$], q1[$], exp_q[$];

  always #5 clk_i = ~clk_i;

  adc_downsample_packer #(.OW(14), .DEC(20), .FIFO_DEPTH(16)) u_dut20 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(d20), .valid_i(v20),
    .data_o(o20), .valid_o(vo20), .ready_i(r20), .overflow_o(ov20));

  adc_downsample_packer #(.OW(14), .DEC(1), .FIFO_DEPTH(16), .FRAME_LEN(4)) u_dut1 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(d1), .valid_i(v1),
    .data_o(o1), .valid_o(vo1), .ready_i(r1), .overflow_o(ov1));

  always @(posedge clk_i) begin
    if (vo20 && r20) q20.push_back(o20);
    if (vo1 && r1)   q1.push_back(o1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic chk_stream(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), got[i], exp[i]);
  endtask

  initial begin
    rst_n_i = 1'b0;
    d20 = '0; d1 = '0; v20 = 1'b0; v1 = 1'b0; r20 = 1'b0; r1 = 1'b0;
    tick(); tick();
    chk("rst_valid20", vo20, 0);
    chk("rst_data20",  o20,  0);
    chk("rst_ovf20",   ov20, 0);
    chk("rst_valid1",  vo1,  0);
    chk("rst_data1",   o1,   0);
    chk("rst_ovf1",    ov1,  0);
    rst_n_i = 1'b1;
    tick();

    // ramp, DEC=20: samples 0,20,40,60 kept
    r20 = 1'b1;
    for (int i = 0; i < 70; i++) begin
      v20 = 1'b1; d20 = 14'(i);
      tick();
    end
    v20 = 1'b0;
    repeat (10) tick();
    exp_q.delete();
`ifdef ADC_DOWNSAMPLE_PACKER_SYNC_EN
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
`endif
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(8'h00); exp_q.push_back(8'(k * 20));
    end
    chk_stream("ramp", q20, exp_q);
    chk("ramp_ovf", ov20, 0);

`ifndef ADC_DOWNSAMPLE_PACKER_SYNC_EN
    // negative sample, one-edge latency
    r1 = 1'b1; d1 = 14'h2001; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    chk("neg_lat0", vo1, 0);
    tick();
    chk("neg_hi_v", vo1, 1);
    chk("neg_hi_d", o1, 8'hE0);
    tick();
    chk("neg_lo_v", vo1, 1);
    chk("neg_lo_d", o1, 8'h01);
    tick();
    chk("neg_end_v", vo1, 0);

    // backpressure hold
    r1 = 1'b0; d1 = 14'h0123; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold_%0d", i), {vo1, o1}, {1'b1, 8'h01});
      tick();
    end
    r1 = 1'b1;
    tick();
    chk("hold_lo", {vo1, o1}, {1'b1, 8'h23});
    tick();
    chk("hold_end_v", vo1, 0);

    // overflow: 16 in FIFO + 1 in packer, sample 17 dropped
    q1.delete();
    r1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      d1 = 14'(i); v1 = 1'b1;
      tick();
      if (i == 16) chk("ovf_before", ov1, 0);
      if (i == 17) chk("ovf_set", ov1, 1);
    end
    v1 = 1'b0; r1 = 1'b1;
    repeat (50) tick();
    exp_q.delete();
    for (int k = 0; k < 17; k++) begin
      exp_q.push_back(8'h00); exp_q.push_back(8'(k));
    end
    chk_stream("ovf", q1, exp_q);
    chk("ovf_sticky", ov1, 1);

    // reset mid-pair
    d1 = 14'h0456; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    tick(); tick();
    chk("mid_pre", {vo1, o1}, {1'b1, 8'h56});
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_v",   vo1, 0);
    chk("mid_rst_d",   o1,  0);
    chk("mid_rst_ovf", ov1, 0);
    tick();
    rst_n_i = 1'b1;
    q20.delete();
    d20 = 14'h0777; v20 = 1'b1;
    tick();
    v20 = 1'b0;
    repeat (5) tick();
    exp_q.delete();
    exp_q.push_back(8'h07); exp_q.push_back(8'h77);
    chk_stream("post_rst", q20, exp_q);
`else
    // frame sync, FRAME_LEN=4
    q1.delete();
    r1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d1 = 14'(16 + i); v1 = 1'b1;
      tick();
    end
    v1 = 1'b0;
    repeat (20) tick();
    exp_q.delete();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(8'h00); exp_q.push_back(8'(16 + k));
    end
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    exp_q.push_back(8'h00); exp_q.push_back(8'h14);
    chk_stream("sync", q1, exp_q);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/adc_downsample_packer.md
Name: adc_downsample_packer

Overview:
- Decimates the filtered ADC sample stream by an integer factor.
- Buffers the kept samples in a small FIFO.
- Serializes each kept sample into a byte stream for the USB transmit path.
- Sits between the FIR output and the FT2232H interface block, all in the 40 MHz ADC clock domain.

Parameters:
- OW, default 14: width of each input sample, two's complement; legal range 9..16.
- USBDW, default 8: output byte width; fixed at 8.
- DEC, default 20: decimation factor; 1 passes every sample.
- FIFO_DEPTH, default 16: sample FIFO entries; must be a power of 2, at least 2.
- FRAME_LEN, default 1024: kept samples per frame; used only with the optional feature.

Ports:
- clk_i, input, 1: 40 MHz clock; single clock domain.
- rst_n_i, input, 1: asynchronous active-low reset.
- data_i, input, OW: filtered sample, two's complement.
- valid_i, input, 1: data_i is valid this cycle.
- data_o, output, USBDW: output byte.
- valid_o, output, 1: data_o is valid.
- ready_i, input, 1: consumer accepts data_o.
- overflow_o, output, 1: sticky flag; a kept sample was dropped.

Behaviour:
- Reset (async assert, sync release):
  - decimation counter = 0, FIFO empty, packer idle.
  - data_o = 0, valid_o = 0, overflow_o = 0.
- Decimator:
  - Counter advances 0..DEC-1 and wraps, only on cycles with valid_i = 1.
  - The sample is kept when the counter is 0 at that edge.
  - Kept sample indices are 0, DEC, 2·DEC, … counting valid samples since reset. The first valid sample after reset is always kept.
  - valid_i = 0 cycles do not advance the counter.
- Sign extension: each kept sample is sign-extended to 16 bits, then written as one FIFO entry at the same edge it is sampled.
- FIFO full:
  - A push is accepted if the FIFO is not full, or if a pop occurs at the same edge.
  - Otherwise the sample is dropped, the FIFO is unchanged, and overflow_o is set to 1.
  - overflow_o stays set until reset.
- Packer states: IDLE, HI, LO.
  - IDLE: when the FIFO is non-empty, pop an entry, load data_o = bits[15:8], valid_o = 1, go to HI.
  - HI: hold data_o and valid_o until an edge with ready_i = 1; then load data_o = bits[7:0] and go to LO.
  - LO: hold until an edge with ready_i = 1. Then:
    - FIFO non-empty: pop and load the next high byte in the same edge (no bubble); go to HI.
    - FIFO empty: valid_o = 0; go to IDLE.
- Output stability: data_o never changes while valid_o = 1 and ready_i = 0.
- Byte order: MSB byte first.
- Throughput: 1 byte per cycle while ready_i = 1. The sustained input limit is 1 kept sample per 2 cycles.
- Latency: with FIFO empty and packer IDLE, a sample kept at edge k gives valid_o = 1 with its high byte after edge k+1.
- ready_i while valid_o = 0 has no effect.
- Reset mid-transfer discards the FIFO contents and the partial byte pair.

Optional Feature:
- Macro ADC_DOWNSAMPLE_PACKER_SYNC_EN.
- When defined: before the first kept sample of each frame, the packer emits sync bytes 0xA5 then 0x5A.
  - A frame starts at the first kept sample after reset and repeats every FRAME_LEN kept samples.
  - Sync bytes use the same valid/ready handshake, with extra states SYNC0 and SYNC1 entered from IDLE or LO before HI.
  - The frame counter counts samples popped from the FIFO, not dropped ones.
- When undefined: no sync bytes, FRAME_LEN is unused, and the state set is IDLE/HI/LO only.

Test Plan:
- Reset, then DEC=20, valid_i=1 every cycle, ramp data_i = 0,1,2,…, ready_i=1 → bytes 00 00, 00 14, 00 28, … (samples 0, 20, 40); overflow_o=0.
- OW=14, DEC=1: data_i=0x2001 (−8191), valid_i one cycle, ready_i=1 → valid_o high one edge later, bytes E0 then 01, then valid_o=0.
- ready_i=0 for 10 cycles while a byte is pending → data_o and valid_o stable throughout; transfer completes on the first ready_i=1 edge.
- DEC=1, valid_i=1 continuously, ready_i=0 → after FIFO_DEPTH (16) pushes plus 1 held in the packer, the next sample is dropped and overflow_o=1. Release ready_i → exactly 17 samples emitted, in order.
- Assert rst_n_i low mid-pair (valid_o=1, state LO) → valid_o=0, data_o=0, overflow_o=0 immediately. After release, the first valid sample is kept.
- With ADC_DOWNSAMPLE_PACKER_SYNC_EN, FRAME_LEN=4, DEC=1, ready_i=1 → stream A5 5A s0H s0L … s3L A5 5A s4H …
